// File: rtl/nfc_cmd_sched_pkg.sv
// Shared widths, queue entry layout and issue-FSM states for the NAND command scheduler.
package nfc_cmd_sched_pkg;

    localparam int unsigned OpcodeWidth  = 6;
    localparam int unsigned IdWidth      = 5;
    localparam int unsigned AddressWidth = 32;
    localparam int unsigned LengthWidth  = 16;
    localparam int unsigned EntryWidth   = 64;
    localparam int unsigned GuardWidth   = 8;

    typedef struct packed {
        logic [OpcodeWidth-1:0]  opcode;
        logic [IdWidth-1:0]      targetId;
        logic [IdWidth-1:0]      sourceId;
        logic [AddressWidth-1:0] address;
        logic [LengthWidth-1:0]  length;
    } cmdEntry_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } issueState_t;

endpackage

// File: rtl/nfc_cmd_fifo.sv
// In-order command FIFO with registered occupancy and a zero-latency head-read port.
module nfc_cmd_fifo
    import nfc_cmd_sched_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [EntryWidth-1:0]   pushData,
    output logic [EntryWidth-1:0]   headData,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(Depth):0]  count
);

    localparam int unsigned PtrWidth   = $clog2(Depth);
    localparam int unsigned CountWidth = $clog2(Depth) + 1;

    logic [EntryWidth-1:0] mem [Depth];
    logic [PtrWidth-1:0]   wrPtr;
    logic [PtrWidth-1:0]   rdPtr;
    logic                  doPush;
    logic                  doPop;

    // A full queue refuses a push even when a pop happens in the same cycle.
    assign full     = (count == CountWidth'(Depth));
    assign empty    = (count == '0);
    assign doPush   = push && !full;
    assign doPop    = pop && !empty;
    assign headData = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PtrWidth'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PtrWidth'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CountWidth'(1);
                2'b01:   count <= count - CountWidth'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nfc_cmd_scheduler.sv
// Holds host NAND commands in order and releases the head only when its way is ready
// and that way's post-issue guard has expired.
module nfc_cmd_scheduler
    import nfc_cmd_sched_pkg::*;
#(
    parameter int unsigned NumberOfWays = 2,
    parameter int unsigned QueueDepth   = 4,
    parameter int unsigned GuardCycles  = 16
) (
    input  logic                          iSystemClock,
    input  logic                          iReset,
    input  logic [OpcodeWidth-1:0]        iHostOpcode,
    input  logic [IdWidth-1:0]            iHostTargetID,
    input  logic [IdWidth-1:0]            iHostSourceID,
    input  logic [AddressWidth-1:0]       iHostAddress,
    input  logic [LengthWidth-1:0]        iHostLength,
    input  logic                          iHostCMDValid,
    output logic                          oHostCMDReady,
    output logic [OpcodeWidth-1:0]        oOpcode,
    output logic [IdWidth-1:0]            oTargetID,
    output logic [IdWidth-1:0]            oSourceID,
    output logic [AddressWidth-1:0]       oAddress,
    output logic [LengthWidth-1:0]        oLength,
    output logic                          oCMDValid,
    input  logic                          iCMDReady,
    input  logic [NumberOfWays-1:0]       iReadyBusy,
    output logic [$clog2(QueueDepth):0]   oQueueCount,
    output logic [NumberOfWays-1:0]       oWayGuardBusy
);

    cmdEntry_t             pushEntry;
    cmdEntry_t             headEntry;
    logic [EntryWidth-1:0] headRaw;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic                  handshake;
    logic                  headWayOk;
    logic                  headEligible;
    issueState_t           state;
    logic [GuardWidth-1:0] guardCnt [NumberOfWays];

    assign pushEntry     = {iHostOpcode, iHostTargetID, iHostSourceID, iHostAddress, iHostLength};
    assign headEntry     = cmdEntry_t'(headRaw);
    assign handshake     = oCMDValid && iCMDReady;
    assign oHostCMDReady = !fifoFull;

    nfc_cmd_fifo #(
        .Depth (QueueDepth)
    ) uFifo (
        .clk      (iSystemClock),
        .reset    (iReset),
        .push     (iHostCMDValid),
        .pop      (handshake),
        .pushData (pushEntry),
        .headData (headRaw),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (oQueueCount)
    );

    // Targets outside the way range (broadcast/reset) stay ungated.
    always_comb begin
        headWayOk = 1'b1;
        for (int w = 0; w < NumberOfWays; w++) begin
            if (headEntry.targetId == IdWidth'(w)) begin
                headWayOk = iReadyBusy[w] && (guardCnt[w] == '0);
            end
        end
    end

    assign headEligible = !fifoEmpty && headWayOk;

    // Eligibility is sampled only in IDLE; a presented command is never withdrawn.
    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            state     <= IDLE;
            oCMDValid <= 1'b0;
            oOpcode   <= '0;
            oTargetID <= '0;
            oSourceID <= '0;
            oAddress  <= '0;
            oLength   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (headEligible) begin
                        oOpcode   <= headEntry.opcode;
                        oTargetID <= headEntry.targetId;
                        oSourceID <= headEntry.sourceId;
                        oAddress  <= headEntry.address;
                        oLength   <= headEntry.length;
                        oCMDValid <= 1'b1;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (iCMDReady) begin
                        oCMDValid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-way guard covers the gap before the die pulls R/B# low.
    always_ff @(posedge iSystemClock) begin
        for (int w = 0; w < NumberOfWays; w++) begin
            if (iReset) begin
                guardCnt[w] <= '0;
            end else if (handshake && (oTargetID == IdWidth'(w))) begin
                guardCnt[w] <= GuardWidth'(GuardCycles);
            end else if (guardCnt[w] != '0) begin
                guardCnt[w] <= guardCnt[w] - GuardWidth'(1);
            end
        end
    end

    always_comb begin
        oWayGuardBusy = '0;
        for (int w = 0; w < NumberOfWays; w++) begin
            oWayGuardBusy[w] = (guardCnt[w] != '0);
        end
    end

endmodule

// File: tb/tb_nfc_cmd_scheduler.sv
// Scoreboard bench for nfc_cmd_scheduler: ordering, latency, guard timing, full queue, ungated and reset.
module tb_nfc_cmd_scheduler;
    import nfc_cmd_sched_pkg::*;

    localparam int GUARD = 16;

    logic        clk = 1'b0;
    logic        iReset = 1'b1;
    logic [5:0]  iHostOpcode = '0;
    logic [4:0]  iHostTargetID = '0;
    logic [4:0]  iHostSourceID = '0;
    logic [31:0] iHostAddress = '0;
    logic [15:0] iHostLength = '0;
    logic        iHostCMDValid = 1'b0;
    logic        oHostCMDReady;
    logic [5:0]  oOpcode;
    logic [4:0]  oTargetID;
    logic [4:0]  oSourceID;
    logic [31:0] oAddress;
    logic [15:0] oLength;
    logic        oCMDValid;
    logic        iCMDReady = 1'b0;
    logic [1:0]  iReadyBusy = 2'b11;
    logic [2:0]  oQueueCount;
    logic [1:0]  oWayGuardBusy;

    nfc_cmd_scheduler #(
        .NumberOfWays (2),
        .QueueDepth   (4),
        .GuardCycles  (GUARD)
    ) dut (
        .iSystemClock  (clk),
        .iReset        (iReset),
        .iHostOpcode   (iHostOpcode),
        .iHostTargetID (iHostTargetID),
        .iHostSourceID (iHostSourceID),
        .iHostAddress  (iHostAddress),
        .iHostLength   (iHostLength),
        .iHostCMDValid (iHostCMDValid),
        .oHostCMDReady (oHostCMDReady),
        .oOpcode       (oOpcode),
        .oTargetID     (oTargetID),
        .oSourceID     (oSourceID),
        .oAddress      (oAddress),
        .oLength       (oLength),
        .oCMDValid     (oCMDValid),
        .iCMDReady     (iCMDReady),
        .iReadyBusy    (iReadyBusy),
        .oQueueCount   (oQueueCount),
        .oWayGuardBusy (oWayGuardBusy)
    );

    always #5 clk = ~clk;

    int        cyc = 0;
    int        checks = 0;
    int        errors = 0;
    cmdEntry_t sbQ[$];
    int        hsCycles[$];
    int        busyRun0 = 0;
    int        lastBusyLen0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake monitor: every accepted command must match the oldest expected entry.
    always @(negedge clk) begin
        cmdEntry_t act;
        cmdEntry_t exp;
        if (!iReset && oCMDValid && iCMDReady) begin
            hsCycles.push_back(cyc);
            checks++;
            act = {oOpcode, oTargetID, oSourceID, oAddress, oLength};
            if (sbQ.size() == 0) begin
                errors++;
                $display("FAIL hs_unexpected cyc=%0d got src=%0d tgt=%0d, required no issue", cyc, oSourceID, oTargetID);
            end else begin
                exp = sbQ.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL hs_fields cyc=%0d got op=%h tgt=%0d src=%0d addr=%h len=%0d, required op=%h tgt=%0d src=%0d addr=%h len=%0d",
                             cyc, act.opcode, act.targetId, act.sourceId, act.address, act.length,
                             exp.opcode, exp.targetId, exp.sourceId, exp.address, exp.length);
                end
            end
        end
        if (oWayGuardBusy[0]) begin
            busyRun0++;
        end else begin
            if (busyRun0 != 0) lastBusyLen0 = busyRun0;
            busyRun0 = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushCmd(input logic [5:0] op, input logic [4:0] tgt, input logic [4:0] src,
                           input logic [31:0] addr, input logic [15:0] len, input bit expectAccept);
        cmdEntry_t e;
        iHostOpcode   = op;
        iHostTargetID = tgt;
        iHostSourceID = src;
        iHostAddress  = addr;
        iHostLength   = len;
        iHostCMDValid = 1'b1;
        e = {op, tgt, src, addr, len};
        if (expectAccept) sbQ.push_back(e);
        tick();
        iHostCMDValid = 1'b0;
    endtask

    task automatic waitHs(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (hsCycles.size() >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (hsCycles.size() >= target) ok = 1'b1;
    endtask

    task automatic test_reset();
        iReset = 1'b1;
        tick();
        tick();
        iReset = 1'b0;
        checks++;
        if (oCMDValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b required 0", oCMDValid); end
        checks++;
        if ({oOpcode, oTargetID, oSourceID, oAddress, oLength} !== 64'd0) begin
            errors++; $display("FAIL reset_fields got %h required 0", {oOpcode, oTargetID, oSourceID, oAddress, oLength});
        end
        checks++;
        if (oQueueCount !== 3'd0) begin errors++; $display("FAIL reset_count got %0d required 0", oQueueCount); end
        checks++;
        if (oHostCMDReady !== 1'b1) begin errors++; $display("FAIL reset_hostready got %b required 1", oHostCMDReady); end
        checks++;
        if (oWayGuardBusy !== 2'b00) begin errors++; $display("FAIL reset_guard got %b required 00", oWayGuardBusy); end
    endtask

    task automatic test_single();
        int n;
        int rise;
        iReadyBusy = 2'b11;
        iCMDReady  = 1'b1;
        n = cyc;
        pushCmd(6'h01, 5'd0, 5'd0, 32'h0000_1000, 16'd2048, 1'b1);
        checks++;
        if (oQueueCount !== 3'd1) begin errors++; $display("FAIL single_count1 got %0d required 1", oQueueCount); end
        rise = -1;
        for (int i = 0; i < 10; i++) begin
            if (oCMDValid) begin
                rise = cyc;
                break;
            end
            tick();
        end
        checks++;
        if (rise != n + 2) begin errors++; $display("FAIL single_latency got %0d required %0d", rise - n, 2); end
        checks++;
        if (oOpcode !== 6'h01 || oAddress !== 32'h0000_1000 || oLength !== 16'd2048 || oTargetID !== 5'd0) begin
            errors++; $display("FAIL single_fields got op=%h addr=%h len=%0d required op=01 addr=00001000 len=2048", oOpcode, oAddress, oLength);
        end
        tick();
        checks++;
        if (oCMDValid !== 1'b0 || oQueueCount !== 3'd0) begin
            errors++; $display("FAIL single_drain got valid=%b count=%0d required valid=0 count=0", oCMDValid, oQueueCount);
        end
        repeat (25) tick();
    endtask

    task automatic test_blocked();
        int base;
        bit ok;
        base = hsCycles.size();
        iReadyBusy = 2'b01;
        iCMDReady  = 1'b1;
        pushCmd(6'h02, 5'd1, 5'd1, 32'h0000_2000, 16'd16, 1'b1);
        pushCmd(6'h03, 5'd0, 5'd2, 32'h0000_3000, 16'd32, 1'b1);
        repeat (8) tick();
        checks++;
        if (oCMDValid !== 1'b0 || hsCycles.size() != base) begin
            errors++; $display("FAIL blocked_hold got valid=%b issues=%0d required valid=0 issues=0", oCMDValid, hsCycles.size() - base);
        end
        checks++;
        if (oQueueCount !== 3'd2) begin errors++; $display("FAIL blocked_count got %0d required 2", oQueueCount); end
        iReadyBusy = 2'b11;
        waitHs(base + 2, 40, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL blocked_release got %0d issues required 2", hsCycles.size() - base); end
        else begin
            checks++;
            if (hsCycles[base + 1] - hsCycles[base] != 2) begin
                errors++; $display("FAIL blocked_gap got %0d required 2", hsCycles[base + 1] - hsCycles[base]);
            end
        end
        repeat (25) tick();
    endtask

    task automatic test_guard();
        int base;
        bit ok;
        base = hsCycles.size();
        iReadyBusy = 2'b11;
        iCMDReady  = 1'b1;
        pushCmd(6'h04, 5'd0, 5'd3, 32'h0000_4000, 16'd64, 1'b1);
        pushCmd(6'h05, 5'd0, 5'd4, 32'h0000_5000, 16'd128, 1'b1);
        waitHs(base + 2, 80, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL guard_issue got %0d issues required 2", hsCycles.size() - base); end
        else begin
            checks++;
            if (hsCycles[base + 1] - hsCycles[base] != GUARD + 2) begin
                errors++; $display("FAIL guard_spacing got %0d required %0d", hsCycles[base + 1] - hsCycles[base], GUARD + 2);
            end
        end
        checks++;
        if (oWayGuardBusy[1] !== 1'b0) begin errors++; $display("FAIL guard_otherway got %b required 0", oWayGuardBusy[1]); end
        repeat (25) tick();
        checks++;
        if (lastBusyLen0 != GUARD) begin errors++; $display("FAIL guard_busylen got %0d required %0d", lastBusyLen0, GUARD); end
    endtask

    task automatic test_full();
        int base;
        bit ok;
        base = hsCycles.size();
        iReadyBusy = 2'b11;
        iCMDReady  = 1'b0;
        for (int s = 1; s <= 4; s++) begin
            pushCmd(6'h06, 5'((s - 1) % 2), 5'(s), 32'(s * 16), 16'(s), 1'b1);
        end
        checks++;
        if (oHostCMDReady !== 1'b0 || oQueueCount !== 3'd4) begin
            errors++; $display("FAIL full_state got ready=%b count=%0d required ready=0 count=4", oHostCMDReady, oQueueCount);
        end
        pushCmd(6'h07, 5'd0, 5'd5, 32'h0000_0050, 16'd5, 1'b0);
        checks++;
        if (oQueueCount !== 3'd4) begin errors++; $display("FAIL full_refuse got %0d required 4", oQueueCount); end
        checks++;
        if (oCMDValid !== 1'b1 || oSourceID !== 5'd1) begin
            errors++; $display("FAIL full_present got valid=%b src=%0d required valid=1 src=1", oCMDValid, oSourceID);
        end
        iCMDReady = 1'b1;
        waitHs(base + 4, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL full_drain got %0d issues required 4", hsCycles.size() - base); end
        repeat (3) tick();
        checks++;
        if (oQueueCount !== 3'd0 || hsCycles.size() != base + 4) begin
            errors++; $display("FAIL full_empty got count=%0d issues=%0d required count=0 issues=4", oQueueCount, hsCycles.size() - base);
        end
    endtask

    task automatic test_ungated();
        int base;
        int n;
        bit ok;
        repeat (25) tick();
        iReadyBusy = 2'b00;
        iCMDReady  = 1'b1;
        base = hsCycles.size();
        n = cyc;
        pushCmd(6'h3F, 5'd31, 5'd7, 32'hDEAD_BEEF, 16'hFFFF, 1'b1);
        waitHs(base + 1, 10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ungated_issue got 0 issues required 1"); end
        else begin
            checks++;
            if (hsCycles[base] != n + 2) begin errors++; $display("FAIL ungated_latency got %0d required 2", hsCycles[base] - n); end
        end
        tick();
        checks++;
        if (oWayGuardBusy !== 2'b00) begin errors++; $display("FAIL ungated_guard got %b required 00", oWayGuardBusy); end
    endtask

    task automatic test_reset_mid();
        int base;
        int n;
        bit ok;
        bit seen;
        iReadyBusy = 2'b11;
        iCMDReady  = 1'b0;
        pushCmd(6'h08, 5'd0, 5'd9, 32'h0000_9000, 16'd9, 1'b1);
        pushCmd(6'h09, 5'd1, 5'd10, 32'h0000_A000, 16'd10, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (oCMDValid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rstmid_present got valid=0 required 1"); end
        iReset = 1'b1;
        tick();
        iReset = 1'b0;
        sbQ.delete();
        checks++;
        if (oCMDValid !== 1'b0 || oQueueCount !== 3'd0 || oWayGuardBusy !== 2'b00 || oHostCMDReady !== 1'b1) begin
            errors++; $display("FAIL rstmid_clear got valid=%b count=%0d guard=%b ready=%b required 0 0 00 1",
                               oCMDValid, oQueueCount, oWayGuardBusy, oHostCMDReady);
        end
        iCMDReady = 1'b1;
        base = hsCycles.size();
        n = cyc;
        pushCmd(6'h0A, 5'd1, 5'd11, 32'h0000_B000, 16'd11, 1'b1);
        waitHs(base + 1, 10, ok);
        checks++;
        if (!ok || hsCycles[base] != n + 2) begin
            errors++; $display("FAIL rstmid_fresh got issues=%0d required one issue at latency 2", hsCycles.size() - base);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_blocked();
        test_guard();
        test_full();
        test_ungated();
        test_reset_mid();
        repeat (3) tick();
        checks++;
        if (sbQ.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d entries required 0", sbQ.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nfc_cmd_scheduler.md
# nfc_cmd_scheduler

Command scheduler directly upstream of the NAND flash controller top. It buffers host NAND commands in a small in-order queue and presents them on the controller's command channel (opcode, target, source, address, length, valid/ready). A command is released only when its target way reports ready on the controller's ready/busy outputs and that way's post-issue guard timer has expired. This keeps commands from being issued to a die that is still busy, or that has just been commanded and whose R/B# has not yet fallen.

## Interface
- NumberOfWays, 2: number of ways; must match the controller instance.
- QueueDepth, 4: queue entries; power of two, 2..16.
- GuardCycles, 16: post-issue block time per way, in iSystemClock cycles, 1..255.
- iSystemClock  in  1  sole clock, SDR 100 MHz.
- iReset  in  1  synchronous, active-high reset.
- iHostOpcode  in  6  command opcode.
- iHostTargetID  in  5  target way/ID.
- iHostSourceID  in  5  source tag, passed through unchanged.
- iHostAddress  in  32  row/column address.
- iHostLength  in  16  transfer length.
- iHostCMDValid  in  1  host command valid.
- oHostCMDReady  out  1  queue can accept a command.
- oOpcode, oTargetID, oSourceID, oAddress, oLength  out  6/5/5/32/16  head-of-queue command fields, driven to the controller.
- oCMDValid  out  1  command valid to the controller.
- iCMDReady  in  1  controller accepts the command.
- iReadyBusy  in  NumberOfWays  per-way ready (1 = ready), taken from the controller's ready/busy output.
- oQueueCount  out  clog2(QueueDepth)+1  number of occupied entries.
- oWayGuardBusy  out  NumberOfWays  per-way guard timer nonzero.

## Operation
- Push: iHostCMDValid & oHostCMDReady writes a 64-bit entry {opcode, target, source, address, length} at the tail.
  - oHostCMDReady = (oQueueCount != QueueDepth), computed from the registered count.
  - At full, a push is refused even if a pop occurs in the same cycle.
- Way selection: way = iHostTargetID when iHostTargetID < NumberOfWays. Otherwise the entry is "ungated", e.g. broadcast or reset commands.
- Head eligibility: queue non-empty and the head entry is either ungated, or iReadyBusy[way] = 1 and guard[way] = 0.
- Issue FSM:
  - IDLE: if head is eligible, register the head fields into the outputs, set oCMDValid, go to PRESENT.
  - PRESENT: hold oCMDValid and all fields stable until iCMDReady.
  - On handshake: pop the head, clear oCMDValid, go to IDLE.
  - Consequence: one idle cycle between consecutive issues; no back-to-back issue.
- Strict in-order issue. An ineligible head blocks all later entries, including entries for ready ways.
- Eligibility is sampled only in IDLE. A deasserting iReadyBusy while in PRESENT does not withdraw the command.
- Guard timers, one 8-bit down-counter per way:
  - Loaded with GuardCycles on a handshake for a gated command to that way.
  - Decrements by 1 per cycle while nonzero; saturates at 0.
  - Ungated commands load no timer.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Push into an empty queue: the entry becomes the head on the next cycle.

## Timing
- Reset (synchronous, one edge) clears:
  - oCMDValid = 0, all command output fields = 0;
  - oQueueCount = 0, oHostCMDReady = 1;
  - oWayGuardBusy = 0, all guard timers = 0, FSM = IDLE.
- Reset mid-PRESENT drops oCMDValid without a handshake. This is acceptable because the controller shares iReset.
- Latency: push accepted in cycle N (empty queue, way ready, guard 0) → oCMDValid high in cycle N+2.
- Handshake in cycle H → oCMDValid low in H+1; the next eligible head asserts oCMDValid in H+2.
- Guard: handshake in cycle H → oWayGuardBusy[w] high from H+1 through H+GuardCycles, low at H+GuardCycles+1.
  - The way becomes eligible in the first IDLE cycle with guard = 0.
- oQueueCount updates one cycle after the push/pop edge.
- No combinational path from any input to any output.

## Structure
- Package nfc_cmd_sched_pkg holds:
  - field widths: opcode 6, ID 5, address 32, length 16;
  - entry width 64 and the packed entry typedef;
  - FSM state enum {IDLE, PRESENT};
  - guard counter width 8.
- Sub-module nfc_cmd_fifo: synchronous FIFO, parameter depth, 64-bit data, registered count.
  - Exposes push/pop/full/empty/count and a head-read port with zero-latency data at the read pointer.
- Guard timers and the issue FSM live in the top module.

## Test plan
- Reset then a single push {op=6'h01, target=0, addr=32'h0000_1000, len=16'd2048} with iReadyBusy=2'b11 and iCMDReady=1 → oCMDValid high exactly 2 cycles after the push, fields match, oQueueCount returns to 0.
- iReadyBusy[1]=0, push target=1 then target=0 → nothing is issued (head blocked). Raise iReadyBusy[1] → target 1 issues first, then target 0.
- Two back-to-back target-0 commands, iReadyBusy held at 1, GuardCycles=16 → second oCMDValid rises no earlier than 17 cycles after the first handshake. oWayGuardBusy[0] is high for exactly 16 cycles.
- Fill with 4 pushes while iCMDReady=0 → oHostCMDReady=0 and a 5th push is ignored. Release iCMDReady → all 4 issue in order with source IDs 1,2,3,4.
- Push target=5'd31 while iReadyBusy=2'b00 → command issues ungated and no guard timer loads.
- Assert iReset during PRESENT → next cycle oCMDValid=0, queue empty, guards 0, and a fresh push issues normally.
